// File: rtl/pipemem_ctrl.sv
// Memory-stage access controller: turns MEM-stage loads/stores into req/ack transactions and stalls the pipeline until done.
// Optional misaligned-access trap (mexc port) is built when PIPEMEM_MISALIGN_TRAP_EN is defined.
module pipemem_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [1:0]  msize,
    input  logic        msign,
    output logic [31:0] mmo,
    output logic        mstall,
`ifdef PIPEMEM_MISALIGN_TRAP_EN
    output logic        mexc,
`endif
    output logic        dreq,
    output logic        dwe,
    output logic [29:0] daddr,
    output logic [3:0]  dbe,
    output logic [31:0] dwdata,
    input  logic [31:0] drdata,
    input  logic        dack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, next_state;
    logic        memop;
    logic        trap;
    logic        start;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  lo;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [31:0] ldata;

    assign memop = mwmem | mm2reg;

`ifdef PIPEMEM_MISALIGN_TRAP_EN
    assign trap = ((msize == 2'b01) && malu[0]) || (msize[1] && (malu[1:0] != 2'b00));
    assign mexc = (state == IDLE) && memop && trap;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        mstall     = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (memop && !trap) begin
                    mstall     = 1'b1;
                    start      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                mstall = 1'b1;
                if (dack) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Store lane selection; unused low address bits are simply ignored for half/word.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = mb;
        case (msize)
            2'b00: begin
                be_n    = 4'b0001 << malu[1:0];
                wdata_n = {4{mb[7:0]}};
            end
            2'b01: begin
                be_n    = malu[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{mb[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = mb;
            end
        endcase
    end

    always_comb begin
        lbyte = drdata[7:0];
        case (lo)
            2'b00: lbyte = drdata[7:0];
            2'b01: lbyte = drdata[15:8];
            2'b10: lbyte = drdata[23:16];
            2'b11: lbyte = drdata[31:24];
            default: lbyte = drdata[7:0];
        endcase
        lhalf = lo[1] ? drdata[31:16] : drdata[15:0];
        case (sz)
            2'b00:   ldata = {{24{sg & lbyte[7]}}, lbyte};
            2'b01:   ldata = {{16{sg & lhalf[15]}}, lhalf};
            default: ldata = drdata;
        endcase
    end

    // Request fields are captured once on entry to BUSY and stay stable until the ack.
    always_ff @(posedge clk) begin
        if (clr) begin
            mmo    <= 32'h0;
            dreq   <= 1'b0;
            dwe    <= 1'b0;
            daddr  <= 30'h0;
            dbe    <= 4'h0;
            dwdata <= 32'h0;
            sz     <= 2'b00;
            sg     <= 1'b0;
            lo     <= 2'b00;
        end else if (start) begin
            dreq   <= 1'b1;
            dwe    <= mwmem;
            daddr  <= malu[31:2];
            dbe    <= be_n;
            dwdata <= wdata_n;
            sz     <= msize;
            sg     <= msign;
            lo     <= malu[1:0];
        end else if ((state == BUSY) && dack) begin
            dreq <= 1'b0;
            if (!dwe) mmo <= ldata;
        end
    end

endmodule

// File: tb/tb_pipemem_ctrl.sv
// Directed self-checking bench for pipemem_ctrl; covers mexc when PIPEMEM_MISALIGN_TRAP_EN is defined.
module tb_pipemem_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        mwmem, mm2reg, msign, dack;
    logic [31:0] malu, mb, drdata;
    logic [1:0]  msize;
    logic [31:0] mmo, dwdata;
    logic        mstall, dreq, dwe;
    logic [29:0] daddr;
    logic [3:0]  dbe;
`ifdef PIPEMEM_MISALIGN_TRAP_EN
    logic        mexc;
`endif

    int checks   = 0;
    int failures = 0;

    int          st;
    logic        idr, cwe, ddr;
    logic [29:0] ca;
    logic [3:0]  cb;
    logic [31:0] cw, cm;

    pipemem_ctrl dut (
        .clk(clk), .clr(clr), .mwmem(mwmem), .mm2reg(mm2reg), .malu(malu), .mb(mb),
        .msize(msize), .msign(msign), .mmo(mmo), .mstall(mstall),
`ifdef PIPEMEM_MISALIGN_TRAP_EN
        .mexc(mexc),
`endif
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata),
        .drdata(drdata), .dack(dack)
    );

    always #5 clk = ~clk;

    // Drives one access, acks it k cycles into BUSY, and records what the DUT did.
    task automatic run_access(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                              input int k, input logic [31:0] rdata,
                              output int stalls, output logic idle_dreq, output logic [29:0] c_addr,
                              output logic [3:0] c_be, output logic [31:0] c_wdata, output logic c_we,
                              output logic [31:0] c_mmo, output logic done_dreq);
        @(negedge clk);
        mwmem = we; mm2reg = re; malu = addr; mb = wdata; msize = size; msign = sign;
        drdata = rdata; dack = 1'b0;
        stalls = 0; idle_dreq = 1'b1; c_addr = '0; c_be = '0; c_wdata = '0; c_we = 1'b0;
        for (int c = 0; c < 40; c++) begin
            dack = (c == k + 1);
            #1;
            if (c == 0) idle_dreq = dreq;
            if (!mstall) break;
            stalls++;
            if (c == 1) begin
                c_addr = daddr; c_be = dbe; c_wdata = dwdata; c_we = dwe;
            end
            @(negedge clk);
        end
        c_mmo = mmo; done_dreq = dreq;
        mwmem = 1'b0; mm2reg = 1'b0; dack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; dack = 1'b1; drdata = 32'hFFFF_FFFF; mwmem = 1'b0; mm2reg = 1'b0;
        malu = 32'h0; mb = 32'h0; msize = 2'b00; msign = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (mmo !== 32'h0) begin failures++; $display("[TB] FAIL reset_mmo got=%h exp=0", mmo); end
        checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL reset_dreq got=%b exp=0", dreq); end
        checks++; if (dwe !== 1'b0) begin failures++; $display("[TB] FAIL reset_dwe got=%b exp=0", dwe); end
        checks++; if (daddr !== 30'h0) begin failures++; $display("[TB] FAIL reset_daddr got=%h exp=0", daddr); end
        checks++; if (dbe !== 4'h0) begin failures++; $display("[TB] FAIL reset_dbe got=%b exp=0", dbe); end
        checks++; if (dwdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_dwdata got=%h exp=0", dwdata); end
        checks++; if (mstall !== 1'b0) begin failures++; $display("[TB] FAIL reset_mstall got=%b exp=0", mstall); end
`ifdef PIPEMEM_MISALIGN_TRAP_EN
        checks++; if (mexc !== 1'b0) begin failures++; $display("[TB] FAIL reset_mexc got=%b exp=0", mexc); end
`endif
        clr = 1'b0; dack = 1'b0;
    endtask

    task automatic test_word_store();
        run_access(1'b1, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 32'h1234_5678,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (st !== 2) begin failures++; $display("[TB] FAIL wstore_stalls got=%0d exp=2", st); end
        checks++; if (ca !== 30'h0400_0002) begin failures++; $display("[TB] FAIL wstore_daddr got=%h exp=04000002", ca); end
        checks++; if (cb !== 4'b1111) begin failures++; $display("[TB] FAIL wstore_dbe got=%b exp=1111", cb); end
        checks++; if (cwe !== 1'b1) begin failures++; $display("[TB] FAIL wstore_dwe got=%b exp=1", cwe); end
        checks++; if (cw !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL wstore_dwdata got=%h exp=deadbeef", cw); end
        checks++; if (cm !== 32'h0) begin failures++; $display("[TB] FAIL wstore_mmo_held got=%h exp=0", cm); end
        checks++; if (ddr !== 1'b0) begin failures++; $display("[TB] FAIL wstore_done_dreq got=%b exp=0", ddr); end
    endtask

    task automatic test_loads();
        run_access(1'b0, 1'b1, 32'h1000_0003, 32'h0, 2'b00, 1'b1, 3, 32'h80FF_1234,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (st !== 5) begin failures++; $display("[TB] FAIL sbyte_stalls got=%0d exp=5", st); end
        checks++; if (cm !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL sbyte_mmo got=%h exp=ffffff80", cm); end
        checks++; if (cwe !== 1'b0) begin failures++; $display("[TB] FAIL sbyte_dwe got=%b exp=0", cwe); end
        checks++; if (ca !== 30'h0400_0000) begin failures++; $display("[TB] FAIL sbyte_daddr got=%h exp=04000000", ca); end
        run_access(1'b0, 1'b1, 32'h1000_0006, 32'h0, 2'b01, 1'b0, 1, 32'hABCD_0000,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (st !== 3) begin failures++; $display("[TB] FAIL uhalf_stalls got=%0d exp=3", st); end
        checks++; if (cm !== 32'h0000_ABCD) begin failures++; $display("[TB] FAIL uhalf_mmo got=%h exp=0000abcd", cm); end
        run_access(1'b0, 1'b1, 32'h0000_0010, 32'h0, 2'b01, 1'b1, 0, 32'h1234_8001,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cm !== 32'hFFFF_8001) begin failures++; $display("[TB] FAIL shalf_mmo got=%h exp=ffff8001", cm); end
        run_access(1'b0, 1'b1, 32'h0000_0021, 32'h0, 2'b00, 1'b0, 0, 32'h0000_9A00,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cm !== 32'h0000_009A) begin failures++; $display("[TB] FAIL ubyte_mmo got=%h exp=0000009a", cm); end
        run_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 2'b10, 1'b1, 2, 32'hCAFE_F00D,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cm !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL word_mmo got=%h exp=cafef00d", cm); end
        checks++; if (st !== 4) begin failures++; $display("[TB] FAIL word_stalls got=%0d exp=4", st); end
    endtask

    task automatic test_stores();
        run_access(1'b1, 1'b0, 32'h2000_0006, 32'h1234_5678, 2'b01, 1'b0, 0, 32'h0,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cb !== 4'b1100) begin failures++; $display("[TB] FAIL hstore_dbe got=%b exp=1100", cb); end
        checks++; if (cw !== 32'h5678_5678) begin failures++; $display("[TB] FAIL hstore_dwdata got=%h exp=56785678", cw); end
        checks++; if (ca !== 30'h0800_0001) begin failures++; $display("[TB] FAIL hstore_daddr got=%h exp=08000001", ca); end
        run_access(1'b1, 1'b0, 32'h0000_0101, 32'hAABB_CCDD, 2'b00, 1'b0, 0, 32'h0,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cb !== 4'b0010) begin failures++; $display("[TB] FAIL bstore_dbe got=%b exp=0010", cb); end
        checks++; if (cw !== 32'hDDDD_DDDD) begin failures++; $display("[TB] FAIL bstore_dwdata got=%h exp=dddddddd", cw); end
        run_access(1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 2'b10, 1'b0, 1, 32'h1111_2222,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cwe !== 1'b1) begin failures++; $display("[TB] FAIL both_dwe got=%b exp=1", cwe); end
        checks++; if (cm !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL both_mmo_held got=%h exp=cafef00d", cm); end
    endtask

    task automatic test_dack_ignored();
        @(negedge clk);
        dack = 1'b1; drdata = 32'h1111_1111;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL idle_dack_dreq got=%b exp=0", dreq); end
        checks++; if (mstall !== 1'b0) begin failures++; $display("[TB] FAIL idle_dack_mstall got=%b exp=0", mstall); end
        checks++; if (mmo !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL idle_dack_mmo got=%h exp=cafef00d", mmo); end
        dack = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 1'b1, 32'h0000_0300, 32'h0, 2'b00, 1'b1, 0, 32'h0000_00F0,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cm !== 32'hFFFF_FFF0) begin failures++; $display("[TB] FAIL b2b_first_mmo got=%h exp=fffffff0", cm); end
        checks++; if (ddr !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_dreq got=%b exp=0", ddr); end
        run_access(1'b0, 1'b1, 32'h0000_0302, 32'h0, 2'b00, 1'b1, 2, 32'h007F_0000,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (idr !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap_dreq got=%b exp=0", idr); end
        checks++; if (st !== 4) begin failures++; $display("[TB] FAIL b2b_second_stalls got=%0d exp=4", st); end
        checks++; if (cm !== 32'h0000_007F) begin failures++; $display("[TB] FAIL b2b_second_mmo got=%h exp=0000007f", cm); end
    endtask

`ifdef PIPEMEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        @(negedge clk);
        mm2reg = 1'b1; malu = 32'h0000_0102; msize = 2'b10; msign = 1'b0; dack = 1'b0;
        #1;
        checks++; if (mexc !== 1'b1) begin failures++; $display("[TB] FAIL trap_mexc got=%b exp=1", mexc); end
        checks++; if (mstall !== 1'b0) begin failures++; $display("[TB] FAIL trap_mstall got=%b exp=0", mstall); end
        @(negedge clk); #1;
        checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL trap_dreq got=%b exp=0", dreq); end
        checks++; if (mmo !== 32'h0000_007F) begin failures++; $display("[TB] FAIL trap_mmo got=%h exp=0000007f", mmo); end
        mm2reg = 1'b0; mwmem = 1'b1; malu = 32'h0000_0105; msize = 2'b01;
        #1;
        checks++; if (mexc !== 1'b1) begin failures++; $display("[TB] FAIL trap_half_mexc got=%b exp=1", mexc); end
        mwmem = 1'b0;
        #1;
        checks++; if (mexc !== 1'b0) begin failures++; $display("[TB] FAIL trap_clear_mexc got=%b exp=0", mexc); end
    endtask
`else
    task automatic test_misalign();
        run_access(1'b0, 1'b1, 32'h0000_0403, 32'h0, 2'b01, 1'b0, 0, 32'hBEEF_1111,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cm !== 32'h0000_BEEF) begin failures++; $display("[TB] FAIL mask_half_mmo got=%h exp=0000beef", cm); end
        run_access(1'b0, 1'b1, 32'h0000_0406, 32'h0, 2'b10, 1'b0, 0, 32'h1357_2468,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (cm !== 32'h1357_2468) begin failures++; $display("[TB] FAIL mask_word_mmo got=%h exp=13572468", cm); end
        checks++; if (ca !== 30'h0000_0101) begin failures++; $display("[TB] FAIL mask_word_daddr got=%h exp=00000101", ca); end
        checks++; if (cb !== 4'b1111) begin failures++; $display("[TB] FAIL mask_word_dbe got=%b exp=1111", cb); end
    endtask
`endif

    task automatic test_clr_busy();
        @(negedge clk);
        mm2reg = 1'b1; malu = 32'h0000_0500; msize = 2'b10; msign = 1'b0; dack = 1'b0;
        @(negedge clk); #1;
        checks++; if (dreq !== 1'b1) begin failures++; $display("[TB] FAIL clr_busy_dreq got=%b exp=1", dreq); end
        clr = 1'b1; dack = 1'b1; drdata = 32'h5555_5555; mm2reg = 1'b0;
        @(negedge clk); #1;
        checks++; if (dreq !== 1'b0) begin failures++; $display("[TB] FAIL clr_dreq got=%b exp=0", dreq); end
        checks++; if (mmo !== 32'h0) begin failures++; $display("[TB] FAIL clr_mmo got=%h exp=0", mmo); end
        checks++; if (mstall !== 1'b0) begin failures++; $display("[TB] FAIL clr_mstall got=%b exp=0", mstall); end
        clr = 1'b0; dack = 1'b0;
        run_access(1'b0, 1'b1, 32'h0000_0600, 32'h0, 2'b10, 1'b0, 0, 32'h0BAD_F00D,
                   st, idr, ca, cb, cw, cwe, cm, ddr);
        checks++; if (st !== 2) begin failures++; $display("[TB] FAIL clr_recover_stalls got=%0d exp=2", st); end
        checks++; if (cm !== 32'h0BAD_F00D) begin failures++; $display("[TB] FAIL clr_recover_mmo got=%h exp=0badf00d", cm); end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_stores();
        test_dack_ignored();
        test_back_to_back();
        test_misalign();
        test_clr_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
